// File: rtl/fsm_run_monitor_pkg.sv
// Shared definitions for the 4-in-a-row detector and its run monitor:
// detector state codes and the monitor FSM encoding.
package fsm_run_monitor_pkg;

    localparam logic [3:0] DET_A = 4'b0000;
    localparam logic [3:0] DET_B = 4'b0001;
    localparam logic [3:0] DET_C = 4'b0010;
    localparam logic [3:0] DET_D = 4'b0011;
    localparam logic [3:0] DET_E = 4'b0100;
    localparam logic [3:0] DET_F = 4'b0101;
    localparam logic [3:0] DET_G = 4'b0110;
    localparam logic [3:0] DET_H = 4'b0111;
    localparam logic [3:0] DET_I = 4'b1000;

    // E means "four or more 0s", I means "four or more 1s"
    localparam logic [3:0] DET_Y_ZERO = DET_E;
    localparam logic [3:0] DET_Y_ONE  = DET_I;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_Z = 2'd1,
        RUN_O = 2'd2
    } mon_state_t;

endpackage

// File: rtl/fsm_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear and increment together load the value 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != '1)) begin
            cnt_d = base + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/fsm_run_monitor.sv
// Run statistics for the 4-in-a-row detector: classifies detections into
// zero-runs and one-runs, counts them, measures their length, offers snapshots.
module fsm_run_monitor
    import fsm_run_monitor_pkg::*;
#(
    parameter int         CNT_W  = 8,
    parameter int         LEN_W  = 8,
    parameter logic [3:0] Y_ZERO = DET_Y_ZERO,
    parameter logic [3:0] Y_ONE  = DET_Y_ONE
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             z,
    input  logic [3:0]       y,
    input  logic             clr_cnt,
    input  logic             rd_req,
    output logic             evt_pulse,
    output logic             evt_kind,
    output logic             run_done,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] one_cnt,
    output logic [LEN_W-1:0] last_len,
    output logic [LEN_W-1:0] max_len,
    output logic             err,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_zero,
    output logic [CNT_W-1:0] rd_one,
    output logic [LEN_W-1:0] rd_max
);

    mon_state_t       state_q, state_d;
    logic             kz, ko, illegal;
    logic             start, startKind, runEnd, lenInc;
    logic [LEN_W-1:0] len;

    logic             evt_pulse_q, evt_kind_q, run_done_q, err_q, rd_valid_q;
    logic [LEN_W-1:0] last_len_q, max_len_q, rd_max_q;
    logic [CNT_W-1:0] rd_zero_q, rd_one_q;

    // A z with an unknown code is flagged and otherwise ignored
    assign kz      = z && (y == Y_ZERO);
    assign ko      = z && (y == Y_ONE);
    assign illegal = z && !kz && !ko;

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        startKind = 1'b0;
        runEnd    = 1'b0;
        lenInc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (kz) begin
                    start   = 1'b1;
                    state_d = RUN_Z;
                end else if (ko) begin
                    start     = 1'b1;
                    startKind = 1'b1;
                    state_d   = RUN_O;
                end
            end
            RUN_Z: begin
                if (kz) begin
                    lenInc = 1'b1;
                end else begin
                    runEnd  = 1'b1;
                    state_d = IDLE;
                    if (ko) begin
                        start     = 1'b1;
                        startKind = 1'b1;
                        state_d   = RUN_O;
                    end
                end
            end
            RUN_O: begin
                if (ko) begin
                    lenInc = 1'b1;
                end else begin
                    runEnd  = 1'b1;
                    state_d = IDLE;
                    if (kz) begin
                        start   = 1'b1;
                        state_d = RUN_Z;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A start in the same cycle as a clear is not counted
    sat_counter #(.W(CNT_W)) u_zero_cnt (
        .clk  (clk),
        .aclr (aclr),
        .clr  (clr_cnt),
        .inc  (start && !startKind && !clr_cnt),
        .q    (zero_cnt)
    );

    sat_counter #(.W(CNT_W)) u_one_cnt (
        .clk  (clk),
        .aclr (aclr),
        .clr  (clr_cnt),
        .inc  (start && startKind && !clr_cnt),
        .q    (one_cnt)
    );

    // Run length restarts at 1 on every start and ignores clr_cnt
    sat_counter #(.W(LEN_W)) u_len (
        .clk  (clk),
        .aclr (aclr),
        .clr  (start),
        .inc  (start || lenInc),
        .q    (len)
    );

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q     <= IDLE;
            evt_pulse_q <= 1'b0;
            evt_kind_q  <= 1'b0;
            run_done_q  <= 1'b0;
            last_len_q  <= '0;
            max_len_q   <= '0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_zero_q   <= '0;
            rd_one_q    <= '0;
            rd_max_q    <= '0;
        end else begin
            state_q     <= state_d;
            evt_pulse_q <= start;
            run_done_q  <= runEnd;
            rd_valid_q  <= rd_req;
            if (start) begin
                evt_kind_q <= startKind;
            end
            if (clr_cnt) begin
                last_len_q <= '0;
                max_len_q  <= '0;
                err_q      <= 1'b0;
            end else begin
                if (runEnd) begin
                    last_len_q <= len;
                    if (len > max_len_q) begin
                        max_len_q <= len;
                    end
                end
                if (illegal) begin
                    err_q <= 1'b1;
                end
            end
            if (rd_req) begin
                rd_zero_q <= zero_cnt;
                rd_one_q  <= one_cnt;
                rd_max_q  <= max_len_q;
            end
        end
    end

    assign evt_pulse = evt_pulse_q;
    assign evt_kind  = evt_kind_q;
    assign run_done  = run_done_q;
    assign last_len  = last_len_q;
    assign max_len   = max_len_q;
    assign err       = err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_zero   = rd_zero_q;
    assign rd_one    = rd_one_q;
    assign rd_max    = rd_max_q;

endmodule

// File: tb/tb_fsm_run_monitor.sv
// Self-checking bench for fsm_run_monitor: directed vectors, a run-level
// reference model compared every cycle, and literal spot checks.
module tb_fsm_run_monitor;

    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       aclr = 1'b1;
    logic       z = 1'b0;
    logic [3:0] y = 4'b0000;
    logic       clr_cnt = 1'b0;
    logic       rd_req = 1'b0;

    logic       evt_pulse, evt_kind, run_done, err, rd_valid;
    logic [7:0] zero_cnt, one_cnt, last_len, max_len, rd_zero, rd_one, rd_max;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    // Reference model state: current run as kind/length, statistics as integers
    int curKind = -1;
    int curLen = 0;
    int zeroN = 0, oneN = 0, lastL = 0, maxL = 0;
    int errM = 0, evtP = 0, evtK = 0, doneP = 0;
    int rdV = 0, rdZ = 0, rdO = 0, rdM = 0;

    fsm_run_monitor dut (
        .clk       (clk),
        .aclr      (aclr),
        .z         (z),
        .y         (y),
        .clr_cnt   (clr_cnt),
        .rd_req    (rd_req),
        .evt_pulse (evt_pulse),
        .evt_kind  (evt_kind),
        .run_done  (run_done),
        .zero_cnt  (zero_cnt),
        .one_cnt   (one_cnt),
        .last_len  (last_len),
        .max_len   (max_len),
        .err       (err),
        .rd_valid  (rd_valid),
        .rd_zero   (rd_zero),
        .rd_one    (rd_one),
        .rd_max    (rd_max)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hold the given inputs for n rising edges; returns 2 time units after the last edge
    task automatic applyStimulus(input logic zV, input logic [3:0] yV, input logic clrV,
                                 input logic rdV_, input logic aclrV, input int n);
        z       = zV;
        y       = yV;
        clr_cnt = clrV;
        rd_req  = rdV_;
        aclr    = aclrV;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model update from the rules: a run continues while its kind keeps matching
    always @(posedge clk) begin
        int m;
        int ended;
        bit started;
        bit illegalM;
        if (aclr) begin
            curKind = -1; curLen = 0;
            zeroN = 0; oneN = 0; lastL = 0; maxL = 0;
            errM = 0; evtP = 0; evtK = 0; doneP = 0;
            rdV = 0; rdZ = 0; rdO = 0; rdM = 0;
        end else begin
            rdV = rd_req ? 1 : 0;
            if (rd_req) begin
                rdZ = zeroN; rdO = oneN; rdM = maxL;
            end
            m = -1;
            if (z && y == 4'b0100) m = 0;
            if (z && y == 4'b1000) m = 1;
            illegalM = z && (m < 0);
            evtP = 0; doneP = 0; ended = -1; started = 0;
            if (curKind >= 0 && m == curKind) begin
                curLen = (curLen + 1 > MAXV) ? MAXV : curLen + 1;
            end else begin
                if (curKind >= 0) begin
                    doneP = 1;
                    ended = curLen;
                end
                if (m >= 0) begin
                    evtP = 1; evtK = m; curKind = m; curLen = 1; started = 1;
                end else begin
                    curKind = -1;
                end
            end
            if (clr_cnt) begin
                zeroN = 0; oneN = 0; lastL = 0; maxL = 0; errM = 0;
            end else begin
                if (ended >= 0) begin
                    lastL = ended;
                    if (ended > maxL) maxL = ended;
                end
                if (illegalM) errM = 1;
                if (started && m == 0 && zeroN < MAXV) zeroN++;
                if (started && m == 1 && oneN < MAXV) oneN++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("evt_pulse", int'(evt_pulse), evtP);
            checkOutput("evt_kind", int'(evt_kind), evtK);
            checkOutput("run_done", int'(run_done), doneP);
            checkOutput("zero_cnt", int'(zero_cnt), zeroN);
            checkOutput("one_cnt", int'(one_cnt), oneN);
            checkOutput("last_len", int'(last_len), lastL);
            checkOutput("max_len", int'(max_len), maxL);
            checkOutput("err", int'(err), errM);
            checkOutput("rd_valid", int'(rd_valid), rdV);
            checkOutput("rd_zero", int'(rd_zero), rdZ);
            checkOutput("rd_one", int'(rd_one), rdO);
            checkOutput("rd_max", int'(rd_max), rdM);
        end
    end

    initial begin
        // Reset held with a zero-run code present
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2);
        checkEn = 1'b1;
        checkOutput("lit_reset_zero_cnt", int'(zero_cnt), 0);
        checkOutput("lit_reset_evt", int'(evt_pulse), 0);
        checkOutput("lit_reset_last", int'(last_len), 0);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_start_evt", int'(evt_pulse), 1);
        checkOutput("lit_start_kind", int'(evt_kind), 0);
        checkOutput("lit_start_zero_cnt", int'(zero_cnt), 1);

        // Zero-run of 5 cycles total
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_zrun_done", int'(run_done), 1);
        checkOutput("lit_zrun_last", int'(last_len), 5);
        checkOutput("lit_zrun_max", int'(max_len), 5);
        checkOutput("lit_zrun_cnt", int'(zero_cnt), 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2);

        // Back-to-back kinds after a clear
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_b2b_done", int'(run_done), 1);
        checkOutput("lit_b2b_last", int'(last_len), 3);
        checkOutput("lit_b2b_evt", int'(evt_pulse), 1);
        checkOutput("lit_b2b_kind", int'(evt_kind), 1);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_b2b_last2", int'(last_len), 2);
        checkOutput("lit_b2b_max", int'(max_len), 3);
        checkOutput("lit_b2b_zero", int'(zero_cnt), 1);
        checkOutput("lit_b2b_one", int'(one_cnt), 1);

        // Four single-cycle zero-runs after a clear, then clear with snapshot
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1);
            applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        end
        checkOutput("lit_four_zero", int'(zero_cnt), 4);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1);
        checkOutput("lit_snap_valid", int'(rd_valid), 1);
        checkOutput("lit_snap_zero", int'(rd_zero), 4);
        checkOutput("lit_snap_cleared", int'(zero_cnt), 0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_snap_drop", int'(rd_valid), 0);

        // Clear in the middle of a run: run still completes with full length
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_midclr_last", int'(last_len), 3);
        checkOutput("lit_midclr_zero", int'(zero_cnt), 0);

        // Clear coinciding with a start and with an end; back-to-back snapshots
        applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("lit_clrstart_evt", int'(evt_pulse), 1);
        checkOutput("lit_clrstart_one", int'(one_cnt), 0);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("lit_clrend_done", int'(run_done), 1);
        checkOutput("lit_clrend_last", int'(last_len), 0);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 2);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2);

        // Illegal code sets sticky err without starting a run
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_illegal_err", int'(err), 1);
        checkOutput("lit_illegal_evt", int'(evt_pulse), 0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("lit_err_sticky", int'(err), 1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("lit_err_clr", int'(err), 0);
        applyStimulus(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("lit_err_aclr", int'(err), 0);

        // Reset mid-run discards the run; z still high starts a new one
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_rstrun_last", int'(last_len), 2);
        checkOutput("lit_rstrun_zero", int'(zero_cnt), 1);

        // Length saturation
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 300);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("lit_len_sat", int'(last_len), 255);
        checkOutput("lit_max_sat", int'(max_len), 255);

        // Event counter saturation
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1);
            applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        end
        checkOutput("lit_cnt_sat", int'(one_cnt), 255);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("lit_snap_one_sat", int'(rd_one), 255);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
